// File: rtl/uart_pkt_scheduler.sv
`timescale 1ns/1ps
// uart_pkt_scheduler
// Frames bytes from a show-ahead byte FIFO into SOF / LEN / payload / checksum
// packets for a UART transmitter. A packet starts when the FIFO holds a full
// payload, when the idle timer runs out with bytes waiting, or on flush.
//
// Build option: define PKT_CRC8_EN to replace the XOR checksum with CRC-8
// (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR). The frame
// format and timing are the same in both builds.
//
// TX handshake: tx_data is offered while tx_valid is high and is taken on a
// rising edge where tx_ready is also high. Once raised, tx_valid stays high and
// tx_data stays unchanged until that edge. The only exception is an empty FIFO
// in PAY, which lowers tx_valid instead of offering a stale byte.
module uart_pkt_scheduler #(
   parameter int unsigned MAX_LEN  = 8,
   parameter int unsigned TIMEOUT  = 1000,
   parameter logic [7:0]  SOF_BYTE = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] fifo_level,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_dout,
   output logic       fifo_rden,
   input  logic       flush,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic       pkt_done,
   output logic [2:0] dbg_state
);

   // Width is sized so the timer can hold TIMEOUT, where it saturates.
   localparam int unsigned TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
   localparam logic [4:0]    MAX_LEN_L  = 5'(MAX_LEN);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SOF  = 3'd1,
      ST_LEN  = 3'd2,
      ST_PAY  = 3'd3,
      ST_CHK  = 3'd4
   } state_t;

   state_t        state_q;
   logic [4:0]    len_q;
   logic [4:0]    rem_q;
   logic [7:0]    chk_q;
   logic [TW-1:0] timer_q;
   logic          pkt_done_q;

   logic          level_nz;
   logic          start;
   logic [4:0]    len_start;
   logic          pay_accept;
   logic [7:0]    chk_d;
   logic [TW-1:0] timer_d;

   // Accumulate one payload byte into the running checksum.
   function automatic logic [7:0] fold_byte(input logic [7:0] acc,
                                            input logic [7:0] data);
      logic [7:0] c;
`ifdef PKT_CRC8_EN
      c = acc ^ data;
      for (int i = 0; i < 8; i++) begin
         if (c[7]) begin
            c = {c[6:0], 1'b0} ^ 8'h07;
         end else begin
            c = {c[6:0], 1'b0};
         end
      end
`else
      c = acc ^ data;
`endif
      return c;
   endfunction

   // Trigger decision and the payload length captured at packet start.
   always_comb begin
      level_nz  = (fifo_level != 5'd0);
      start     = (fifo_level >= MAX_LEN_L) ||
                  (level_nz && (timer_q == TIMER_LAST)) ||
                  (flush && level_nz);
      len_start = (fifo_level >= MAX_LEN_L) ? MAX_LEN_L : fifo_level;
   end

   // The idle timer runs only while bytes are waiting and holds at TIMEOUT.
   always_comb begin
      timer_d = timer_q;
      if (!level_nz) begin
         timer_d = '0;
      end else if (timer_q != TIMER_MAX) begin
         timer_d = timer_q + TIMER_ONE;
      end
   end

   // Payload acceptance. An empty FIFO blocks the pop, so it is never underrun.
   always_comb begin
      pay_accept = (state_q == ST_PAY) && !fifo_empty && tx_ready;
      chk_d      = fold_byte(chk_q, fifo_dout);
   end

   // Packet sequencer. It holds the frame bookkeeping and the pkt_done pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         len_q      <= 5'd0;
         rem_q      <= 5'd0;
         chk_q      <= 8'h00;
         timer_q    <= '0;
         pkt_done_q <= 1'b0;
      end else begin
         pkt_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_SOF;
                  len_q   <= len_start;
                  rem_q   <= len_start;
                  chk_q   <= 8'h00;
                  timer_q <= '0;
               end else begin
                  timer_q <= timer_d;
               end
            end
            ST_SOF: begin
               if (tx_ready) begin
                  state_q <= ST_LEN;
               end
            end
            ST_LEN: begin
               if (tx_ready) begin
                  state_q <= ST_PAY;
               end
            end
            ST_PAY: begin
               if (pay_accept) begin
                  chk_q <= chk_d;
                  rem_q <= rem_q - 5'd1;
                  // rem_q counts the bytes still owed. Leave PAY when the last one is taken.
                  if (rem_q == 5'd1) begin
                     state_q <= ST_CHK;
                  end
               end
            end
            ST_CHK: begin
               if (tx_ready) begin
                  state_q    <= ST_IDLE;
                  pkt_done_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Byte offered to the UART in each state. It is driven from state, so the
   // reset that clears state also drops tx_valid at once.
   always_comb begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      case (state_q)
         ST_SOF: begin
            tx_valid = 1'b1;
            tx_data  = SOF_BYTE;
         end
         ST_LEN: begin
            tx_valid = 1'b1;
            tx_data  = {3'b000, len_q};
         end
         ST_PAY: begin
            tx_valid = !fifo_empty;
            tx_data  = fifo_dout;
         end
         ST_CHK: begin
            tx_valid = 1'b1;
            tx_data  = chk_q;
         end
         default: begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
         end
      endcase
   end

   assign fifo_rden = pay_accept;
   assign busy      = (state_q != ST_IDLE);
   assign pkt_done  = pkt_done_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_pkt_scheduler.sv
`timescale 1ns/1ps
// Bench for uart_pkt_scheduler: a small model FIFO feeds the DUT, and expected
// frames are queued as bytes are written. The monitor pops them as the UART
// accepts bytes.
module tb_uart_pkt_scheduler;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned TIMEOUT = 16;
   localparam logic [7:0]  SOF     = 8'hA5;

   logic       clk;
   logic       rst_n;
   logic [4:0] fifo_level;
   logic       fifo_empty;
   logic [7:0] fifo_dout;
   logic       fifo_rden;
   logic       flush;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       pkt_done;
   logic [2:0] dbg_state;

   uart_pkt_scheduler #(
      .MAX_LEN (MAX_LEN),
      .TIMEOUT (TIMEOUT),
      .SOF_BYTE(SOF)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fifo_level(fifo_level),
      .fifo_empty(fifo_empty),
      .fifo_dout (fifo_dout),
      .fifo_rden (fifo_rden),
      .flush     (flush),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .pkt_done  (pkt_done),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   // ---------------- model FIFO ----------------
   logic [7:0] fmem [16];
   logic [3:0] frd, fwr;
   logic [4:0] fcnt;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       do_rd, do_wr;

   assign do_rd      = fifo_rden && (fcnt != 5'd0);
   assign do_wr      = wr_en && ((fcnt != 5'd16) || do_rd);
   assign fifo_level = fcnt;
   assign fifo_empty = (fcnt == 5'd0);
   assign fifo_dout  = fmem[frd];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frd  <= 4'd0;
         fwr  <= 4'd0;
         fcnt <= 5'd0;
      end else begin
         if (do_wr) begin
            fmem[fwr] <= wr_data;
            fwr       <= fwr + 4'd1;
         end
         if (do_rd) frd <= frd + 4'd1;
         fcnt <= fcnt + 5'(do_wr) - 5'(do_rd);
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Reference checksum, written bit by bit: feedback = crc MSB xor data bit.
   function automatic logic [7:0] ref_fold(input logic [7:0] acc, input logic [7:0] b);
      logic [7:0] c;
      logic       fb;
      c = acc;
`ifdef PKT_CRC8_EN
      for (int i = 7; i >= 0; i--) begin
         fb = c[7] ^ b[i];
         c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
`else
      fb = 1'b0;
      c  = c ^ b ^ {7'd0, fb};
`endif
      return c;
   endfunction

   logic [7:0] exp_q[$];
   logic [7:0] model_q[$];

   // Queue the frame that the next n bytes in FIFO order will produce.
   task automatic expect_frame(input int n);
      logic [7:0] c, b;
      c = 8'h00;
      exp_q.push_back(SOF);
      exp_q.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         b = model_q.pop_front();
         exp_q.push_back(b);
         c = ref_fold(c, b);
      end
      exp_q.push_back(c);
   endtask

   // ---------------- monitor ----------------
   int         hs_cnt = 0;
   int         pop_cnt = 0;
   int         done_cnt = 0;
   int         valid_cnt = 0;
   logic       prev_stall = 1'b0;
   logic       prev_done = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] mon_exp;

   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_stall) begin
            check("tx_hold_valid", tx_valid, 1);
            check("tx_hold_data", tx_data, prev_data);
         end
         if (tx_valid) valid_cnt++;
         if (tx_valid && tx_ready) begin
            hs_cnt++;
            check("tx_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_exp = exp_q.pop_front();
               check("tx_byte", tx_data, mon_exp);
            end
         end
         if (fifo_rden) begin
            pop_cnt++;
            check("rden_nonempty", fifo_empty, 0);
            check("rden_handshake", tx_valid && tx_ready, 1);
         end
         if (pkt_done) begin
            done_cnt++;
            check("done_idle", busy, 0);
            check("done_single", prev_done, 0);
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_done  = pkt_done;
      end else begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
      end
   end

   // ---------------- drivers ----------------
   logic rdy_mode = 1'b0;
   int   rdy_phase = 0;

   // When enabled, ready is high one cycle in three.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode) begin
            tx_ready  = (rdy_phase == 0);
            rdy_phase = (rdy_phase == 2) ? 0 : rdy_phase + 1;
         end
      end
   end

   // Call at posedge+1. Returns at posedge+1 after the write edge.
   task automatic write_byte(input logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      model_q.push_back(b);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !busy) break;
      end
      repeat (2) @(posedge clk);
      #1;
      check({tag, "_drained"}, exp_q.size(), 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   // ---------------- main sequence ----------------
   int p0, d0, h0, v0, start_cyc, lat, n;

   initial begin
      rst_n    = 1'b0;
      wr_en    = 1'b0;
      wr_data  = 8'h00;
      flush    = 1'b0;
      tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx_valid", tx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_rden", fifo_rden, 0);
      check("rst_done", pkt_done, 0);
      check("rst_state", dbg_state, 3'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-length packet triggered by level reaching MAX_LEN.
      tx_ready = 1'b1;
      p0 = pop_cnt; d0 = done_cnt;
      for (int i = 1; i <= 8; i++) write_byte(8'(i));
      expect_frame(8);
      wait_drain("full", 200);
      check("full_pops", pop_cnt - p0, 8);
      check("full_done", done_cnt - d0, 1);

      // Timeout packet: three bytes, no flush.
      p0 = pop_cnt; d0 = done_cnt;
      write_byte(8'h01);
      start_cyc = cyc;
      write_byte(8'h02);
      write_byte(8'h04);
      expect_frame(3);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (tx_valid) break;
      end
      lat = cyc - start_cyc;
      check("tmo_latency_in_window", (lat >= int'(TIMEOUT) - 1) && (lat <= int'(TIMEOUT) + 1), 1);
      wait_drain("tmo", 200);
      check("tmo_pops", pop_cnt - p0, 3);
      check("tmo_done", done_cnt - d0, 1);

      // Flush with ready high one cycle in three.
      p0 = pop_cnt; d0 = done_cnt;
      write_byte(8'h55);
      write_byte(8'hAA);
      expect_frame(2);
      pulse_flush();
      check("flush_started", busy, 1);
      rdy_mode = 1'b1;
      wait_drain("flush", 300);
      rdy_mode = 1'b0;
      #1;
      tx_ready = 1'b1;
      check("flush_pops", pop_cnt - p0, 2);
      check("flush_done", done_cnt - d0, 1);

      // Overfill: 12 bytes while the UART stalls. The first packet stays at 8
      // bytes, and the last 4 go out after the idle timeout.
      p0 = pop_cnt; d0 = done_cnt;
      tx_ready = 1'b0;
      for (int i = 0; i < 12; i++) write_byte(8'h10 + 8'(i));
      check("ovf_busy", busy, 1);
      expect_frame(8);
      expect_frame(4);
      tx_ready = 1'b1;
      wait_drain("ovf", 400);
      check("ovf_pops", pop_cnt - p0, 12);
      check("ovf_done", done_cnt - d0, 2);

      // Random short packets, started by flush, with random backpressure.
      for (int k = 0; k < 4; k++) begin
         p0 = pop_cnt; d0 = done_cnt;
         n = $urandom_range(1, MAX_LEN - 1);
         for (int i = 0; i < n; i++) write_byte(8'($urandom_range(0, 255)));
         expect_frame(n);
         rdy_mode = ($urandom_range(0, 1) == 1);
         pulse_flush();
         wait_drain("rand", 400);
         rdy_mode = 1'b0;
         #1;
         tx_ready = 1'b1;
         check("rand_pops", pop_cnt - p0, n);
         check("rand_done", done_cnt - d0, 1);
      end

      // Reset in the middle of the payload.
      tx_ready = 1'b1;
      h0 = hs_cnt;
      for (int i = 0; i < 8; i++) write_byte(8'h30 + 8'(i));
      expect_frame(8);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #1;
         if (hs_cnt - h0 >= 5) break;
      end
      @(posedge clk);
      #2;
      check("mid_in_payload", dbg_state, 3'd3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_tx_valid", tx_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_rden", fifo_rden, 0);
      exp_q.delete();
      model_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      v0 = valid_cnt;
      repeat (40) @(posedge clk);
      #1;
      check("post_rst_quiet", valid_cnt - v0, 0);

      // Recovery: a normal flushed packet after the reset.
      p0 = pop_cnt; d0 = done_cnt;
      write_byte(8'hC3);
      write_byte(8'h3C);
      write_byte(8'h81);
      expect_frame(3);
      pulse_flush();
      wait_drain("recover", 200);
      check("recover_pops", pop_cnt - p0, 3);
      check("recover_done", done_cnt - d0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
